axis_pkt_fifo: RTL and testbench

- Store-and-forward AXI-Stream packet FIFO, one instance per slave input, directly upstream of the multi-slave AXI-Stream switch.
- Presents m_valid only once a complete packet (TLAST seen) is buffered.
- The switch locks onto a slave for a whole packet, so a slow producer can no longer stall the shared master path mid-packet.
- Oversized packets fall back to cut-through so the block can never deadlock.

---
 rtl/axis_pkt_fifo.sv | 168 ++++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
// Store-and-forward AXI-Stream packet FIFO placed in front of one slave port of
// the shared AXI-Stream switch. Output valid is held off until a whole packet
// (TLAST seen) is buffered, so the switch never locks onto a slave that then
// stalls mid-packet. A packet larger than DEPTH is released in cut-through mode
// so the block cannot deadlock; that event sets the sticky oversize flag.
//
// Optional build macro: AXIS_PKT_FIFO_LEVEL_EN adds the 'level' output
// (wr_ptr - rd_ptr, range 0..DEPTH). Without it the port is absent.
//
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   s_valid/s_ready       input beat handshake (s_ready = not full)
//   s_data/s_dest/s_id    input payload
//   s_last                input end of packet
//   m_valid/m_ready       output beat handshake towards the switch
//   m_data/m_dest/m_id    output payload, show-ahead from the head entry
//   m_last                output end of packet
//   oversize              sticky: a packet exceeded DEPTH and was cut through
//   level                 (macro only) current fill level
// -----------------------------------------------------------------------------
module axis_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [DEST_WIDTH-1:0] s_dest,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [DEST_WIDTH-1:0] m_dest,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic                  m_last,
`ifdef AXIS_PKT_FIFO_LEVEL_EN
  output logic [ADDR_W:0]       level,
`endif
  output logic                  oversize
);

  localparam int unsigned WORD_W = DATA_WIDTH + DEST_WIDTH + ID_WIDTH + 1;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_SEND = 2'd1,
    ST_CUT  = 2'd2
  } state_t;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_pkt_cnt;
  state_t            r_state;
  logic              r_oversize;

  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [PTR_W-1:0]  w_pkt_cnt_nxt;
  state_t            w_state_nxt;
  logic              w_set_oversize;
  logic              w_empty;
  logic              w_full;
  logic              w_full_nxt;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_pkt_inc;
  logic              w_pkt_dec;
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_rd_word;

  // Occupancy from registered pointers only, so s_ready never depends on m_ready.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign s_ready   = !w_full;
  assign w_wr_en   = s_valid && !w_full;
  assign m_valid   = (r_state != ST_HOLD) && !w_empty;
  assign w_rd_en   = m_valid && m_ready;
  assign w_pkt_inc = w_wr_en && s_last;
  assign w_pkt_dec = w_rd_en && m_last;

  // Show-ahead read of the head entry.
  assign w_wr_word = {s_last, s_id, s_dest, s_data};
  assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign m_data    = w_rd_word[DATA_WIDTH-1:0];
  assign m_dest    = w_rd_word[DATA_WIDTH +: DEST_WIDTH];
  assign m_id      = w_rd_word[DATA_WIDTH+DEST_WIDTH +: ID_WIDTH];
  assign m_last    = w_rd_word[WORD_W-1];
  assign oversize  = r_oversize;

`ifdef AXIS_PKT_FIFO_LEVEL_EN
  assign level = r_wr_ptr - r_rd_ptr;
`endif

  assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr_en);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_en);
  assign w_full_nxt   = (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                        (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);

  // Complete-packet count; simultaneous in/out packet ends cancel.
  always_comb begin
    w_pkt_cnt_nxt = r_pkt_cnt;
    if (w_pkt_inc && !w_pkt_dec) begin
      w_pkt_cnt_nxt = r_pkt_cnt + PTR_W'(1);
    end else if (w_pkt_dec && !w_pkt_inc) begin
      w_pkt_cnt_nxt = r_pkt_cnt - PTR_W'(1);
    end
  end

  // Next-state logic. HOLD looks at next-cycle count/fill so a freshly
  // completed packet is presented on the very next cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_set_oversize = 1'b0;
    unique case (r_state)
      ST_HOLD: begin
        if (w_pkt_cnt_nxt != '0) begin
          w_state_nxt = ST_SEND;
        end else if (w_full_nxt) begin
          w_state_nxt    = ST_CUT;
          w_set_oversize = 1'b1;
        end
      end
      ST_SEND, ST_CUT: begin
        if (w_pkt_dec) begin
          w_state_nxt = (w_pkt_cnt_nxt != '0) ? ST_SEND : ST_HOLD;
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  // Control state; reset drops everything buffered, partial packets included.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_state    <= ST_HOLD;
      r_oversize <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_pkt_cnt  <= w_pkt_cnt_nxt;
      r_state    <= w_state_nxt;
      r_oversize <= r_oversize | w_set_oversize;
    end
  end

  // Payload storage; no reset needed, entries are only read once written.
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wr_word;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_fifo
// Directed bench for axis_pkt_fifo (DEPTH=16, DATA_WIDTH=64): single packet
// latency, partial packet hold-off, full/backpressure, oversize cut-through,
// coincident in/out packet ends, and reset with data buffered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic [0:0]  s_dest;
  logic [0:0]  s_id;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [0:0]  m_dest;
  logic [0:0]  m_id;
  logic        m_last;
  logic        oversize;
`ifdef AXIS_PKT_FIFO_LEVEL_EN
  logic [4:0]  level;
`endif

  axis_pkt_fifo #(
    .DATA_WIDTH(64), .DEST_WIDTH(1), .ID_WIDTH(1), .DEPTH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dest(s_dest), .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_dest(m_dest), .m_id(m_id), .m_last(m_last),
`ifdef AXIS_PKT_FIFO_LEVEL_EN
    .level(level),
`endif
    .oversize(oversize)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Received beats (sampled on the falling edge before the accepting edge).
  logic [63:0] rx_d[$];
  logic        rx_l[$];
  logic [1:0]  rx_side[$];
  int          rx_c[$];
  logic [63:0] exp_d[$];
  logic        exp_l[$];

  always @(negedge aclk) begin
    if (aresetn && m_valid && m_ready) begin
      rx_d.push_back(m_data);
      rx_l.push_back(m_last);
      rx_side.push_back({m_id, m_dest});
      rx_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clear_rx();
    rx_d.delete(); rx_l.delete(); rx_side.delete(); rx_c.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  // Append a packet of n beats starting at d0, last on the final beat if 'l'.
  task automatic push_exp(input logic [63:0] d0, input int n, input logic l);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(d0 + 64'(i));
      exp_l.push_back(l && (i == n - 1));
    end
  endtask

  // Drive one beat; returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [63:0] d, input logic l);
    int budget;
    budget  = 200;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_dest  = d[0];
    s_id    = d[1];
    @(negedge aclk);
    while (!s_ready && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    if (budget == 0) check("send_timeout", 64'(s_ready), 64'd1);
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] d0, input int n, input logic l);
    for (int i = 0; i < n; i++) send_beat(d0 + 64'(i), l && (i == n - 1));
  endtask

  // Compare captured beats with the expected list; c0 >= 0 also checks that
  // beat i was taken in cycle c0+i (no bubbles, exact start).
  task automatic check_rx(input string tag, input int c0);
    int n;
    check($sformatf("%s_count", tag), 64'(rx_d.size()), 64'(exp_d.size()));
    n = (rx_d.size() < exp_d.size()) ? rx_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), rx_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), 64'(rx_l[i]), 64'(exp_l[i]));
      check($sformatf("%s_side%0d", tag, i), 64'(rx_side[i]), 64'(exp_d[i][1:0]));
      if (c0 >= 0) check($sformatf("%s_cyc%0d", tag, i), 64'(rx_c[i]), 64'(c0 + i));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    aresetn = 1'b0;
    s_valid = 1'b0; s_data = '0; s_dest = '0; s_id = '0; s_last = 1'b0;
    m_ready = 1'b0;
    tick(3);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_oversize", 64'(oversize), 64'd0);
`ifdef AXIS_PKT_FIFO_LEVEL_EN
    check("rst_level", 64'(level), 64'd0);
`endif
    tick(1);

    // Single 4-beat packet: output starts the cycle after the last beat.
    clear_rx();
    m_ready = 1'b1;
    send_pkt(64'h10, 4, 1'b1);
    k = cyc;
    tick(8);
    push_exp(64'h10, 4, 1'b1);
    check_rx("single", k);

    // Partial packet is held back until its last beat arrives.
    clear_rx();
    send_pkt(64'h20, 3, 1'b0);
    tick(10);
    check("partial_no_out", 64'(rx_d.size()), 64'd0);
    check("partial_pkt_cnt", 64'(dut.r_pkt_cnt), 64'd0);
    send_beat(64'h23, 1'b1);
    tick(8);
    push_exp(64'h20, 4, 1'b1);
    check_rx("partial", -1);

    // Two 8-beat packets fill the FIFO under backpressure, then drain.
    clear_rx();
    m_ready = 1'b0;
    send_pkt(64'h30, 8, 1'b1);
    send_pkt(64'h38, 8, 1'b1);
    @(negedge aclk);
    check("full_s_ready", 64'(s_ready), 64'd0);
    check("full_pkt_cnt", 64'(dut.r_pkt_cnt), 64'd2);
    check("full_m_valid", 64'(m_valid), 64'd1);
    tick(1);
    m_ready = 1'b1;
    k = cyc;
    tick(20);
    push_exp(64'h30, 8, 1'b1);
    push_exp(64'h38, 8, 1'b1);
    check_rx("drain", k);
    check("drain_s_ready", 64'(s_ready), 64'd1);

    // 20-beat packet exceeds DEPTH and is cut through.
    clear_rx();
    m_ready = 1'b0;
    check("ovs_pre_flag", 64'(oversize), 64'd0);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send_beat(64'h40 + 64'(i), i == 19);
          if (i == 15) begin
            check("ovs_state_cut", 64'(dut.r_state), 64'd2);
            check("ovs_flag_set", 64'(oversize), 64'd1);
            check("ovs_s_ready", 64'(s_ready), 64'd0);
          end
        end
      end
      begin
        tick(20);
        m_ready = 1'b1;
      end
    join
    tick(30);
    push_exp(64'h40, 20, 1'b1);
    check_rx("ovs", -1);
    check("ovs_state_hold", 64'(dut.r_state), 64'd0);
    check("ovs_flag_sticky", 64'(oversize), 64'd1);

    // Output last and input last on the same edge.
    clear_rx();
    m_ready = 1'b0;
    send_pkt(64'h60, 2, 1'b1);
    send_beat(64'h70, 1'b0);
    m_ready = 1'b1;
    tick(1);
    s_valid = 1'b1; s_data = 64'h71; s_dest = 1'b1; s_id = 1'b0; s_last = 1'b1;
    @(negedge aclk);
    check("sim_pre_m_last", 64'(m_last), 64'd1);
    check("sim_pre_pkt_cnt", 64'(dut.r_pkt_cnt), 64'd1);
`ifdef AXIS_PKT_FIFO_LEVEL_EN
    check("sim_pre_level", 64'(level), 64'd2);
`endif
    tick(1);
    s_valid = 1'b0; s_last = 1'b0;
    check("sim_post_pkt_cnt", 64'(dut.r_pkt_cnt), 64'd1);
    check("sim_post_state", 64'(dut.r_state), 64'd1);
`ifdef AXIS_PKT_FIFO_LEVEL_EN
    check("sim_post_level", 64'(level), 64'd2);
`endif
    tick(8);
    push_exp(64'h60, 2, 1'b1);
    push_exp(64'h70, 2, 1'b1);
    check_rx("sim", -1);

    // Reset while 5 beats are buffered in SEND.
    clear_rx();
    m_ready = 1'b0;
    send_pkt(64'h80, 2, 1'b1);
    send_pkt(64'h82, 3, 1'b0);
    check("rst2_pre_state", 64'(dut.r_state), 64'd1);
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst2_m_valid", 64'(m_valid), 64'd0);
    check("rst2_s_ready", 64'(s_ready), 64'd1);
    check("rst2_oversize", 64'(oversize), 64'd0);
    check("rst2_pkt_cnt", 64'(dut.r_pkt_cnt), 64'd0);
`ifdef AXIS_PKT_FIFO_LEVEL_EN
    check("rst2_level", 64'(level), 64'd0);
`endif
    tick(1);
    m_ready = 1'b1;
    send_pkt(64'h90, 2, 1'b1);
    tick(8);
    push_exp(64'h90, 2, 1'b1);
    check_rx("rst2", -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
